fir_mac_seq: RTL and testbench

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

---
 rtl/fir_mac_seq.sv | 119 +++++++++++
 tb/tb_fir_mac_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// Sequential FIR filter: a single multiplier walks the taps one per cycle,
// producing one unsigned result every NUM_TAPS+2 cycles.
module fir_mac_seq #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int COEFF_WIDTH = 8,
  parameter  int NUM_TAPS    = 4,
  localparam int AW          = $clog2(NUM_TAPS),
  localparam int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   coeff_we,
  input  logic [AW-1:0]          coeff_addr,
  input  logic [COEFF_WIDTH-1:0] coeff_wdata,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [ACC_WIDTH-1:0]   out_data,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam int            PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_TAPS - 1);
  localparam logic [AW:0]   TAPS_EXT   = (AW + 1)'(NUM_TAPS);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   x_q [NUM_TAPS];
  logic [DATA_WIDTH-1:0]   x_d [NUM_TAPS];
  logic [COEFF_WIDTH-1:0]  c_q [NUM_TAPS];
  logic [COEFF_WIDTH-1:0]  c_d [NUM_TAPS];
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [ACC_WIDTH-1:0]    out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;

  logic                    accept;
  logic                    coeff_ok;
  logic [PROD_WIDTH-1:0]   prod;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  // Addresses beyond the last tap exist when NUM_TAPS is not a power of two.
  assign coeff_ok  = coeff_we && (state_q == IDLE) && ({1'b0, coeff_addr} < TAPS_EXT);
  assign prod      = PROD_WIDTH'(x_q[idx_q]) * PROD_WIDTH'(c_q[idx_q]);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    c_d         = c_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    if (coeff_ok) begin
      c_d[coeff_addr] = coeff_wdata;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          x_d[0] = in_data;
          for (int k = 1; k < NUM_TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + ACC_WIDTH'(prod);
        if (idx_q == LAST_IDX) begin
          out_data_d  = acc_d;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
      acc_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Scoreboard bench for fir_mac_seq: a 4-tap instance (index 0) and a 3-tap
// instance (index 1) driven with directed samples and hand-computed results.
module tb_fir_mac_seq;

  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int AWB  = 2;
  localparam int ACCW = 18;

  logic            clk = 1'b0;
  logic            reset      [2];
  logic            coeffWe    [2];
  logic [AWB-1:0]  coeffAddr  [2];
  logic [CW-1:0]   coeffWdata [2];
  logic            inValid    [2];
  logic [DW-1:0]   inData     [2];
  logic            inReady    [2];
  logic            outValid   [2];
  logic [ACCW-1:0] outData    [2];
  logic            busy       [2];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [ACCW-1:0] expQ0 [$];
  logic [ACCW-1:0] expQ1 [$];
  int              latQ0 [$];
  int              latQ1 [$];

  fir_mac_seq #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(4)) dut4 (
    .clk(clk), .reset(reset[0]), .coeff_we(coeffWe[0]), .coeff_addr(coeffAddr[0]),
    .coeff_wdata(coeffWdata[0]), .in_valid(inValid[0]), .in_data(inData[0]),
    .in_ready(inReady[0]), .out_valid(outValid[0]), .out_data(outData[0]), .busy(busy[0])
  );

  fir_mac_seq #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(3)) dut3 (
    .clk(clk), .reset(reset[1]), .coeff_we(coeffWe[1]), .coeff_addr(coeffAddr[1]),
    .coeff_wdata(coeffWdata[1]), .in_valid(inValid[1]), .in_data(inData[1]),
    .in_ready(inReady[1]), .out_valid(outValid[1]), .out_data(outData[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  task automatic pushExp(input int d, input logic [ACCW-1:0] e, input int edgeNo);
    if (d == 0) begin
      expQ0.push_back(e);
      latQ0.push_back(edgeNo);
    end else begin
      expQ1.push_back(e);
      latQ1.push_back(edgeNo);
    end
  endtask

  // Result appears after the NUM_TAPS-th edge following the accepting edge,
  // i.e. NUM_TAPS+1 edges counting the accepting one.
  always @(negedge clk) begin
    if (outValid[0] === 1'b1) begin
      if (expQ0.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL dut4 unexpected out_valid: got out_data %0d, required no strobe", outData[0]);
      end else begin
        logic [ACCW-1:0] e;
        int a;
        e = expQ0.pop_front();
        a = latQ0.pop_front();
        checkOutput("dut4 out_data", 32'(outData[0]), 32'(e));
        checkOutput("dut4 latency", cyc - a, 4);
      end
    end
  end

  always @(negedge clk) begin
    if (outValid[1] === 1'b1) begin
      if (expQ1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL dut3 unexpected out_valid: got out_data %0d, required no strobe", outData[1]);
      end else begin
        logic [ACCW-1:0] e;
        int a;
        e = expQ1.pop_front();
        a = latQ1.pop_front();
        checkOutput("dut3 out_data", 32'(outData[1]), 32'(e));
        checkOutput("dut3 latency", cyc - a, 3);
      end
    end
  end

  task automatic writeCoeff(input int d, input logic [AWB-1:0] addr, input logic [CW-1:0] data);
    coeffWe[d]    = 1'b1;
    coeffAddr[d]  = addr;
    coeffWdata[d] = data;
    @(negedge clk);
    coeffWe[d]    = 1'b0;
  endtask

  // Offers one sample (optionally with a coefficient write on the same edge);
  // returns at the negedge after the accepting edge.
  task automatic applyStimulus(input int d, input logic [DW-1:0] data, input logic [ACCW-1:0] expVal,
                               input bit expectOut, input bit withCoeff,
                               input logic [AWB-1:0] caddr, input logic [CW-1:0] cdata);
    int budget = 0;
    inValid[d] = 1'b1;
    inData[d]  = data;
    if (withCoeff) begin
      coeffWe[d]    = 1'b1;
      coeffAddr[d]  = caddr;
      coeffWdata[d] = cdata;
    end
    while (inReady[d] !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (inReady[d] !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept timeout dut%0d: got in_ready %b, required 1", d, inReady[d]);
      inValid[d] = 1'b0;
      coeffWe[d] = 1'b0;
      return;
    end
    if (expectOut) pushExp(d, expVal, cyc + 1);
    @(negedge clk);
    inValid[d] = 1'b0;
    coeffWe[d] = 1'b0;
  endtask

  // Holds in_valid high with data 7 on the 4-tap instance for three acceptances.
  task automatic holdStream(input logic [ACCW-1:0] e0, input logic [ACCW-1:0] e1, input logic [ACCW-1:0] e2);
    logic [ACCW-1:0] exps [3];
    int got      = 0;
    int budget   = 0;
    int lastEdge = -1;
    exps[0] = e0;
    exps[1] = e1;
    exps[2] = e2;
    inValid[0] = 1'b1;
    inData[0]  = 8'd7;
    while (got < 3 && budget < 100) begin
      if (inReady[0] === 1'b1) begin
        pushExp(0, exps[got], cyc + 1);
        if (lastEdge >= 0) checkOutput("accept spacing", cyc + 1 - lastEdge, 6);
        lastEdge = cyc + 1;
        got++;
      end
      @(negedge clk);
      budget++;
    end
    inValid[0] = 1'b0;
    checkOutput("stream acceptances", got, 3);
  endtask

  task automatic waitDrain(input int d);
    int budget = 0;
    while (((d == 0) ? expQ0.size() : expQ1.size()) != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("pending results", (d == 0) ? expQ0.size() : expQ1.size(), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d]      = 1'b1;
      coeffWe[d]    = 1'b0;
      coeffAddr[d]  = '0;
      coeffWdata[d] = '0;
      inValid[d]    = 1'b0;
      inData[d]     = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("dut4 in_ready in reset", inReady[0], 0);
    checkOutput("dut3 in_ready in reset", inReady[1], 0);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    #1;
    checkOutput("out_valid after reset", outValid[0], 0);
    checkOutput("out_data after reset", 32'(outData[0]), 0);
    checkOutput("busy after reset", busy[0], 0);
    checkOutput("in_ready after reset", inReady[0], 1);
    @(negedge clk);

    // Basic filtering with c = {1,2,3,4}
    writeCoeff(0, 0, 1); writeCoeff(0, 1, 2); writeCoeff(0, 2, 3); writeCoeff(0, 3, 4);
    applyStimulus(0, 10, 10,  1, 0, 0, 0);
    applyStimulus(0, 20, 40,  1, 0, 0, 0);
    applyStimulus(0, 30, 100, 1, 0, 0, 0);
    applyStimulus(0, 40, 200, 1, 0, 0, 0);
    waitDrain(0);

    // Delay line {40,30,20,10} -> three 7s under a continuously held in_valid
    holdStream(257, 261, 202);
    waitDrain(0);

    // Full-scale values must not wrap
    writeCoeff(0, 0, 255); writeCoeff(0, 1, 255); writeCoeff(0, 2, 255); writeCoeff(0, 3, 255);
    applyStimulus(0, 255, 70380,  1, 0, 0, 0);
    applyStimulus(0, 255, 133620, 1, 0, 0, 0);
    applyStimulus(0, 255, 196860, 1, 0, 0, 0);
    applyStimulus(0, 255, 260100, 1, 0, 0, 0);
    applyStimulus(0, 1,   195077, 1, 1, 0, 2);
    waitDrain(0);

    // Abort in the second ACCUM cycle; the aborted sample must never strobe
    applyStimulus(0, 99, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset[0] = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", busy[0], 0);
    checkOutput("abort out_valid", outValid[0], 0);
    checkOutput("abort in_ready", inReady[0], 0);
    checkOutput("abort out_data", 32'(outData[0]), 0);
    reset[0] = 1'b0;
    repeat (8) @(negedge clk);
    writeCoeff(0, 0, 1);
    applyStimulus(0, 5, 5, 1, 0, 0, 0);
    waitDrain(0);
    writeCoeff(0, 1, 1); writeCoeff(0, 2, 1); writeCoeff(0, 3, 1);
    applyStimulus(0, 6, 11, 1, 0, 0, 0);
    waitDrain(0);

    // 3-tap instance: out-of-range and mid-computation writes are dropped
    writeCoeff(1, 0, 1); writeCoeff(1, 1, 2); writeCoeff(1, 2, 3); writeCoeff(1, 3, 9);
    applyStimulus(1, 10, 10,  1, 0, 0, 0);
    applyStimulus(1, 20, 40,  1, 0, 0, 0);
    applyStimulus(1, 30, 100, 1, 0, 0, 0);
    writeCoeff(1, 0, 100);
    applyStimulus(1, 40, 160, 1, 0, 0, 0);
    waitDrain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
